// File: rtl/fpga_rst_seq.sv
// Reset sequencer for the FPGA emulation top: synchronizes and debounces the board reset
// pin, waits for clock lock, then releases the slow-clock-generator reset before the MCU reset.
module fpga_rst_seq #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 64,
    parameter int SYNC_STAGES     = 2,
    parameter int STRAP_W         = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rstn_pad_i,
    input  logic               locked_i,
    input  logic [STRAP_W-1:0] strap_i,
    output logic               slow_rstn_o,
    output logic               rstn_o,
    output logic [STRAP_W-1:0] strap_o,
    output logic [1:0]         cause_o
);

    localparam int MAX_CYC = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_PAD  = 2'd2;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RUN} state_e;

    logic [SYNC_STAGES-1:0] pad_sync_q, pad_sync_d;
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic [STRAP_W-1:0]     strap_sync_q [SYNC_STAGES];
    logic [STRAP_W-1:0]     strap_sync_d [SYNC_STAGES];

    logic               pad_s, lock_s;
    logic [STRAP_W-1:0] strap_s;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               slow_rstn_q, slow_rstn_d;
    logic               rstn_q, rstn_d;
    logic [STRAP_W-1:0] strap_q, strap_d;
    logic [1:0]         cause_q, cause_d;

    always_comb begin
        pad_sync_d      = {pad_sync_q[SYNC_STAGES-2:0], rstn_pad_i};
        lock_sync_d     = {lock_sync_q[SYNC_STAGES-2:0], locked_i};
        strap_sync_d[0] = strap_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            strap_sync_d[i] = strap_sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pad_sync_q  <= '0;
            lock_sync_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                strap_sync_q[i] <= '0;
            end
        end else begin
            pad_sync_q  <= pad_sync_d;
            lock_sync_q <= lock_sync_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                strap_sync_q[i] <= strap_sync_d[i];
            end
        end
    end

    assign pad_s   = pad_sync_q[SYNC_STAGES-1];
    assign lock_s  = lock_sync_q[SYNC_STAGES-1];
    assign strap_s = strap_sync_q[SYNC_STAGES-1];

    // The counter debounces the pad in DEBOUNCE and RUN and times the release gap in HOLD.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        slow_rstn_d = slow_rstn_q;
        rstn_d      = rstn_q;
        strap_d     = strap_q;
        cause_d     = cause_q;
        case (state_q)
            IDLE: begin
                slow_rstn_d = 1'b0;
                rstn_d      = 1'b0;
                cnt_d       = '0;
                if (lock_s && pad_s) begin
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!lock_s || !pad_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = HOLD;
                    cnt_d       = '0;
                    slow_rstn_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lock_s || !pad_s) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    slow_rstn_d = 1'b0;
                    cause_d     = !lock_s ? CAUSE_LOCK : CAUSE_PAD;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    rstn_d  = 1'b1;
                    strap_d = strap_s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // Lock loss drops both resets at once; the pad must stay low to count.
                if (!lock_s || (!pad_s && cnt_q == DEB_LAST)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    slow_rstn_d = 1'b0;
                    rstn_d      = 1'b0;
                    cause_d     = !lock_s ? CAUSE_LOCK : CAUSE_PAD;
                end else if (pad_s) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            slow_rstn_q <= 1'b0;
            rstn_q      <= 1'b0;
            strap_q     <= '0;
            cause_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slow_rstn_q <= slow_rstn_d;
            rstn_q      <= rstn_d;
            strap_q     <= strap_d;
            cause_q     <= cause_d;
        end
    end

    assign slow_rstn_o = slow_rstn_q;
    assign rstn_o      = rstn_q;
    assign strap_o     = strap_q;
    assign cause_o     = cause_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Self-checking bench for fpga_rst_seq: directed edge-timing scenarios plus randomized
// stimulus, all checked against a run-length model of the reset sequencing rules.
module tb_fpga_rst_seq;

    localparam int D  = 4;
    localparam int H  = 3;
    localparam int S  = 2;
    localparam int SW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          rstn_pad_i = 1'b0;
    logic          locked_i = 1'b0;
    logic [SW-1:0] strap_i = '0;
    logic          slow_rstn_o;
    logic          rstn_o;
    logic [SW-1:0] strap_o;
    logic [1:0]    cause_o;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    fpga_rst_seq #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .SYNC_STAGES    (S),
        .STRAP_W        (SW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rstn_pad_i (rstn_pad_i),
        .locked_i   (locked_i),
        .strap_i    (strap_i),
        .slow_rstn_o(slow_rstn_o),
        .rstn_o     (rstn_o),
        .strap_o    (strap_o),
        .cause_o    (cause_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: synchronizers as pure delay lines; sequencing expressed as the
    // length of the current run of good (locked and pad-high) samples, and in the running
    // phase as the length of the current run of pad-low samples.
    logic          m_slow = 1'b0;
    logic          m_rstn = 1'b0;
    logic [SW-1:0] m_strap = '0;
    logic [1:0]    m_cause = '0;
    int            good_len = 0;
    int            low_len = 0;
    logic          pad_dly [S];
    logic          lock_dly [S];
    logic [SW-1:0] strap_dly [S];

    initial begin
        for (int i = 0; i < S; i++) begin
            pad_dly[i] = 1'b0; lock_dly[i] = 1'b0; strap_dly[i] = '0;
        end
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) begin
                m_slow = 1'b0; m_rstn = 1'b0; m_strap = '0; m_cause = 2'd0;
                good_len = 0; low_len = 0;
                for (int i = 0; i < S; i++) begin
                    pad_dly[i] = 1'b0; lock_dly[i] = 1'b0; strap_dly[i] = '0;
                end
            end else begin
                logic          ps, ls;
                logic [SW-1:0] ss;
                ps = pad_dly[S-1]; ls = lock_dly[S-1]; ss = strap_dly[S-1];
                if (!m_rstn) begin
                    if (ls && ps) begin
                        good_len++;
                        if (good_len == D + 1) m_slow = 1'b1;
                        if (good_len == D + 1 + H) begin
                            m_rstn = 1'b1; m_strap = ss; low_len = 0;
                        end
                    end else begin
                        if (m_slow) m_cause = !ls ? 2'd1 : 2'd2;
                        m_slow = 1'b0; good_len = 0;
                    end
                end else begin
                    if (!ls) begin
                        m_slow = 1'b0; m_rstn = 1'b0; m_cause = 2'd1; good_len = 0; low_len = 0;
                    end else if (!ps) begin
                        low_len++;
                        if (low_len == D) begin
                            m_slow = 1'b0; m_rstn = 1'b0; m_cause = 2'd2; good_len = 0; low_len = 0;
                        end
                    end else begin
                        low_len = 0;
                    end
                end
                for (int i = S - 1; i > 0; i--) begin
                    pad_dly[i] = pad_dly[i-1]; lock_dly[i] = lock_dly[i-1]; strap_dly[i] = strap_dly[i-1];
                end
                pad_dly[0] = rstn_pad_i; lock_dly[0] = locked_i; strap_dly[0] = strap_i;
            end
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (cmp_en) begin
            chk("model_slow_rstn", 32'(slow_rstn_o), 32'(m_slow));
            chk("model_rstn", 32'(rstn_o), 32'(m_rstn));
            chk("model_strap", 32'(strap_o), 32'(m_strap));
            chk("model_cause", 32'(cause_o), 32'(m_cause));
            chk("rstn_implies_slow", 32'(rstn_o & ~slow_rstn_o), 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic pad_low_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            rstn_pad_i = 1'b0;
        end
    endtask

    initial begin
        int run_left;
        #1 rst_i = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_slow", 32'(slow_rstn_o), 32'd0);
        chk("reset_rstn", 32'(rstn_o), 32'd0);
        chk("reset_strap", 32'(strap_o), 32'd0);
        chk("reset_cause", 32'(cause_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        locked_i = 1'b1;
        strap_i = 2'b01;
        repeat (5) @(negedge clk_i);
        chk("idle_no_pad_rstn", 32'(rstn_o), 32'd0);

        // Bring-up: pad first sampled high at edge 1.
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_i);
            rstn_pad_i = 1'b1;
            strap_i = (k <= 8) ? 2'b01 : 2'b11;
            @(posedge clk_i);
            #1;
            chk($sformatf("s1_slow_e%0d", k), 32'(slow_rstn_o), 32'(k >= 7));
            chk($sformatf("s1_rstn_e%0d", k), 32'(rstn_o), 32'(k >= 10));
            chk($sformatf("s1_strap_e%0d", k), 32'(strap_o), (k >= 10) ? 32'd1 : 32'd0);
        end

        // Straps move after RUN entry; the latched value must hold.
        @(negedge clk_i);
        strap_i = 2'b10;
        repeat (10) @(negedge clk_i);
        chk("strap_hold_run", 32'(strap_o), 32'd1);

        // Short pad glitch in RUN is ignored.
        pad_low_cycles(2);
        @(negedge clk_i);
        rstn_pad_i = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("run_glitch_rstn", 32'(rstn_o), 32'd1);
        chk("run_glitch_slow", 32'(slow_rstn_o), 32'd1);

        // Held pad low in RUN: resets fall at edge n+S+D-1.
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_i);
            rstn_pad_i = 1'b0;
            @(posedge clk_i);
            #1;
            chk($sformatf("pad_rstn_e%0d", k), 32'(rstn_o), 32'(k < 6));
            chk($sformatf("pad_slow_e%0d", k), 32'(slow_rstn_o), 32'(k < 6));
        end
        chk("pad_cause", 32'(cause_o), 32'd2);

        // Resequence latches the new strap value.
        @(negedge clk_i);
        rstn_pad_i = 1'b1;
        repeat (15) @(negedge clk_i);
        chk("reseq_rstn", 32'(rstn_o), 32'd1);
        chk("reseq_strap", 32'(strap_o), 32'd2);

        // One-cycle lock loss in RUN: resets fall at edge n+2.
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            locked_i = (k == 1) ? 1'b0 : 1'b1;
            @(posedge clk_i);
            #1;
            chk($sformatf("lock_rstn_e%0d", k), 32'(rstn_o), 32'(k < 3));
            chk($sformatf("lock_slow_e%0d", k), 32'(slow_rstn_o), 32'(k < 3));
        end
        chk("lock_cause", 32'(cause_o), 32'd1);
        repeat (20) @(negedge clk_i);
        chk("lock_reseq_rstn", 32'(rstn_o), 32'd1);

        // Pad glitch during DEBOUNCE (seen by the FSM at cnt=2) restarts the count.
        pad_low_cycles(8);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk_i);
            rstn_pad_i = (k == 4) ? 1'b0 : 1'b1;
            @(posedge clk_i);
            #1;
            chk($sformatf("dbg_slow_e%0d", k), 32'(slow_rstn_o), 32'(k >= 11));
            chk($sformatf("dbg_rstn_e%0d", k), 32'(rstn_o), 32'(k >= 14));
        end

        // Async reset while in HOLD, then a clean restart.
        pad_low_cycles(8);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            rstn_pad_i = 1'b1;
        end
        @(posedge clk_i);
        #1;
        chk("hold_slow_before_rst", 32'(slow_rstn_o), 32'd1);
        chk("hold_rstn_before_rst", 32'(rstn_o), 32'd0);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_slow", 32'(slow_rstn_o), 32'd0);
        chk("async_rst_rstn", 32'(rstn_o), 32'd0);
        chk("async_rst_strap", 32'(strap_o), 32'd0);
        chk("async_rst_cause", 32'(cause_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("rst_slow_e%0d", k), 32'(slow_rstn_o), 32'(k >= 7));
            chk($sformatf("rst_rstn_e%0d", k), 32'(rstn_o), 32'(k >= 10));
        end
        chk("rst_strap", 32'(strap_o), 32'd2);

        // Randomized traffic checked by the model every cycle.
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            if (run_left == 0) begin
                rstn_pad_i = ($urandom_range(0, 3) != 0);
                run_left = rstn_pad_i ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 7));
            end
            run_left--;
            locked_i = ($urandom_range(0, 79) != 0);
            strap_i = SW'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_i = 1'b1;
                @(negedge clk_i);
                #1 rst_i = 1'b0;
            end
        end
        repeat (2) @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
